brownout_seq: RTL and testbench

- Digital sequencer for the analog brownout detector, running on the always-on digital supply domain.
- Enables the detector, latches its trip configuration, and ignores the comparator while it settles.
- Debounces the brownout comparator output and drives a system reset with a guaranteed minimum hold time after supply recovery.
- Tracks undervoltage as a sticky status flag.

---
 rtl/brownout_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_brownout_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brownout_seq.sv
// brownout_seq
//   Digital sequencer for the analog brownout detector (always-on domain).
//   It enables the detector and latches its trip selects. While the detector
//   settles, its output is ignored. After that, the brownout comparator is
//   debounced and drives a system reset request. The reset is held for a
//   minimum time after the supply recovers. Undervoltage is tracked as a
//   sticky flag.
//
//   Optional feature, macro BROWNOUT_EVT_CNT_EN:
//     When defined, adds clr_evt / evt_cnt: a saturating 8-bit count of irq
//     pulses. When undefined, these ports and their logic do not exist.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           software enable for brownout supervision
//   otrip_cfg    requested brownout trip select (latched on OFF->SETTLE)
//   vtrip_cfg    requested undervoltage trip select (latched on OFF->SETTLE)
//   brout_in     async detector brownout output, 1 = avdd below trip
//   vunder_in    async detector undervoltage output, 1 = below trip
//   clr_vunder   one-cycle pulse clearing vunder_flag
//   clr_evt      (optional) one-cycle pulse clearing evt_cnt
//   evt_cnt      (optional) saturating irq event count
//   ena          detector enable
//   otrip        applied brownout trip select
//   vtrip        applied undervoltage trip select
//   bo_rst       system reset request, 1 = hold system in reset
//   irq          one-cycle pulse on each MONITOR->FAULT entry
//   vunder_flag  sticky undervoltage indication
//   state        FSM state: OFF=0 SETTLE=1 MONITOR=2 FAULT=3 HOLD=4
//
// state   | meaning
// --------+--------------------------------------------------------------
// OFF     | detector disabled, no reset request
// SETTLE  | detector enabled, comparator ignored for SETTLE_CYC cycles
// MONITOR | watching brout; DEB_CYC consecutive highs -> FAULT
// FAULT   | reset asserted; DEB_CYC consecutive lows -> HOLD
// HOLD    | reset held HOLD_CYC cycles; any brout high -> FAULT

module brownout_seq #(
  parameter int SETTLE_CYC = 64,
  parameter int DEB_CYC    = 8,
  parameter int HOLD_CYC   = 1024,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] otrip_cfg,
  input  logic [2:0] vtrip_cfg,
  input  logic       brout_in,
  input  logic       vunder_in,
  input  logic       clr_vunder,
`ifdef BROWNOUT_EVT_CNT_EN
  input  logic       clr_evt,
  output logic [7:0] evt_cnt,
`endif
  output logic       ena,
  output logic [2:0] otrip,
  output logic [2:0] vtrip,
  output logic       bo_rst,
  output logic       irq,
  output logic       vunder_flag,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MONITOR = 3'd2,
    ST_FAULT   = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] DEB_MAX     = CW'(DEB_CYC);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] dcnt_q, dcnt_d, dcnt_inc;
  logic [2:0]    otrip_q, otrip_d;
  logic [2:0]    vtrip_q, vtrip_d;
  logic          ena_q, bo_rst_q, irq_q, irq_d;
  logic          vflag_q, vflag_d;
  logic          brout_m_q, brout_s_q;
  logic          vunder_m_q, vunder_s_q;
  logic          supervising;

  // Two-flop synchronizers for the asynchronous detector outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      brout_m_q  <= 1'b0;
      brout_s_q  <= 1'b0;
      vunder_m_q <= 1'b0;
      vunder_s_q <= 1'b0;
    end else begin
      brout_m_q  <= brout_in;
      brout_s_q  <= brout_m_q;
      vunder_m_q <= vunder_in;
      vunder_s_q <= vunder_m_q;
    end
  end

  // The debounce count saturates, so an increment never wraps
  assign dcnt_inc = (dcnt_q == DEB_MAX) ? dcnt_q : dcnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    otrip_d = otrip_q;
    vtrip_d = vtrip_q;
    irq_d   = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (en) begin
          state_d = ST_SETTLE;
          otrip_d = otrip_cfg;
          vtrip_d = vtrip_cfg;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_MONITOR;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      ST_MONITOR: begin
        if (brout_s_q) begin
          dcnt_d = dcnt_inc;
          if (dcnt_inc == DEB_MAX) begin
            state_d = ST_FAULT;
            irq_d   = 1'b1;
          end
        end else begin
          dcnt_d = '0;
        end
      end
      ST_FAULT: begin
        if (!brout_s_q) begin
          dcnt_d = dcnt_inc;
          if (dcnt_inc == DEB_MAX) state_d = ST_HOLD;
        end else begin
          dcnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (brout_s_q)               state_d = ST_FAULT;
        else if (cnt_q == HOLD_LAST) state_d = ST_MONITOR;
        else                         cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_OFF;
    endcase

    // Disabling overrides every other transition
    if (state_q != ST_OFF && !en) begin
      state_d = ST_OFF;
      irq_d   = 1'b0;
    end

    if (state_d != state_q) begin
      cnt_d  = '0;
      dcnt_d = '0;
    end
  end

  assign supervising = (state_q == ST_MONITOR) || (state_q == ST_FAULT) ||
                       (state_q == ST_HOLD);

  // Entering OFF clears the flag. Otherwise a new undervoltage sample beats
  // a simultaneous clear.
  always_comb begin
    vflag_d = vflag_q;
    if (state_d == ST_OFF)               vflag_d = 1'b0;
    else if (vunder_s_q && supervising)  vflag_d = 1'b1;
    else if (clr_vunder)                 vflag_d = 1'b0;
  end

  // Outputs are decoded from the next state and registered, so they change
  // together with state and have no combinational input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      otrip_q  <= 3'd0;
      vtrip_q  <= 3'd0;
      ena_q    <= 1'b0;
      bo_rst_q <= 1'b0;
      irq_q    <= 1'b0;
      vflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      otrip_q  <= otrip_d;
      vtrip_q  <= vtrip_d;
      ena_q    <= (state_d != ST_OFF);
      bo_rst_q <= (state_d == ST_FAULT) || (state_d == ST_HOLD);
      irq_q    <= irq_d;
      vflag_q  <= vflag_d;
    end
  end

`ifdef BROWNOUT_EVT_CNT_EN
  logic [7:0] evt_q;

  // A clear that coincides with an irq leaves that irq counted
  always_ff @(posedge clk) begin
    if (rst)                        evt_q <= 8'd0;
    else if (clr_evt)               evt_q <= irq_q ? 8'd1 : 8'd0;
    else if (irq_q && evt_q != 8'hff) evt_q <= evt_q + 8'd1;
  end

  assign evt_cnt = evt_q;
`endif

  assign ena         = ena_q;
  assign otrip       = otrip_q;
  assign vtrip       = vtrip_q;
  assign bo_rst      = bo_rst_q;
  assign irq         = irq_q;
  assign vunder_flag = vflag_q;
  assign state       = state_q;

endmodule

// File: tb/tb_brownout_seq.sv
module tb_brownout_seq;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int HOLD   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] otrip_cfg = 3'd0;
  logic [2:0] vtrip_cfg = 3'd0;
  logic       brout_in = 1'b0;
  logic       vunder_in = 1'b0;
  logic       clr_vunder = 1'b0;
  logic       ena, bo_rst, irq, vunder_flag;
  logic [2:0] otrip, vtrip, state;
`ifdef BROWNOUT_EVT_CNT_EN
  logic       clr_evt = 1'b0;
  logic [7:0] evt_cnt;
`endif

  brownout_seq #(
    .SETTLE_CYC(SETTLE),
    .DEB_CYC   (DEB),
    .HOLD_CYC  (HOLD),
    .CW        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .otrip_cfg  (otrip_cfg),
    .vtrip_cfg  (vtrip_cfg),
    .brout_in   (brout_in),
    .vunder_in  (vunder_in),
    .clr_vunder (clr_vunder),
`ifdef BROWNOUT_EVT_CNT_EN
    .clr_evt    (clr_evt),
    .evt_cnt    (evt_cnt),
`endif
    .ena        (ena),
    .otrip      (otrip),
    .vtrip      (vtrip),
    .bo_rst     (bo_rst),
    .irq        (irq),
    .vunder_flag(vunder_flag),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   irq_cnt = 0;

  // Independent count of irq pulses seen on the port
  always @(posedge clk) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

  function automatic logic [7:0] obs(string tag);
    if (tag == "state")   return {5'd0, state};
    if (tag == "ena")     return {7'd0, ena};
    if (tag == "bo_rst")  return {7'd0, bo_rst};
    if (tag == "irq")     return {7'd0, irq};
    if (tag == "vflag")   return {7'd0, vunder_flag};
    if (tag == "otrip")   return {5'd0, otrip};
    if (tag == "vtrip")   return {5'd0, vtrip};
    if (tag == "irq_cnt") return irq_cnt[7:0];
`ifdef BROWNOUT_EVT_CNT_EN
    if (tag == "evt_cnt") return evt_cnt;
`endif
    return 8'hxx;
  endfunction

  task automatic push(string tag, logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.tag);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  initial begin
    // reset state
    step(2);
    push("state", 0); push("ena", 0); push("bo_rst", 0); push("irq", 0);
    push("vflag", 0); push("otrip", 0); push("vtrip", 0);
    drain();
    rst = 1'b0;
    step(1);
    push("state", 0); push("ena", 0);
    drain();

    // 1: enable, config latch, settle ignores brout
    otrip_cfg = 3'b101; vtrip_cfg = 3'b011; en = 1'b1;
    step(1);
    push("ena", 1); push("otrip", 5); push("vtrip", 3); push("state", 1); push("bo_rst", 0);
    drain();
    brout_in = 1'b1;
    step(1);
    brout_in = 1'b0;
    push("state", 1);
    drain();
    step(2);
    push("state", 1);
    drain();
    step(1);
    push("state", 2);
    drain();
    step(5);
    push("state", 2); push("bo_rst", 0); push("irq_cnt", 0);
    drain();

    // 2: glitch filter, then a real fault
    brout_in = 1'b1;
    step(2);
    brout_in = 1'b0;
    step(5);
    push("state", 2); push("bo_rst", 0); push("irq_cnt", 0);
    drain();
    brout_in = 1'b1;
    step(4);
    push("state", 2); push("bo_rst", 0);
    drain();
    step(1);
    push("state", 3); push("bo_rst", 1); push("irq", 1);
    drain();
    step(1);
    push("irq", 0); push("irq_cnt", 1); push("ena", 1);
    drain();

    // 3: recovery hold
    brout_in = 1'b0;
    step(4);
    push("state", 3); push("bo_rst", 1);
    drain();
    step(1);
    push("state", 4); push("bo_rst", 1);
    drain();
    step(HOLD - 1);
    push("state", 4); push("bo_rst", 1);
    drain();
    step(1);
    push("state", 2); push("bo_rst", 0); push("ena", 1);
    drain();

    // 4: re-fault during hold
    brout_in = 1'b1;
    step(5);
    push("state", 3);
    drain();
    step(1);
    push("irq_cnt", 2);
    drain();
    brout_in = 1'b0;
    step(5);
    push("state", 4);
    drain();
    step(5);
    brout_in = 1'b1;
    step(2);
    push("state", 4);
    drain();
    step(1);
    push("state", 3); push("bo_rst", 1);
    drain();
    step(2);
    push("irq_cnt", 2);
    drain();
    brout_in = 1'b0;
    step(4);
    push("state", 3);
    drain();
    step(1);
    push("state", 4);
    drain();
    step(HOLD - 1);
    push("state", 4); push("bo_rst", 1);
    drain();
    step(1);
    push("state", 2); push("bo_rst", 0);
    drain();

    // 5: config ignored outside OFF, disable mid-fault
    otrip_cfg = 3'b010;
    step(2);
    push("otrip", 5);
    drain();
    vunder_in = 1'b1;
    step(3);
    push("vflag", 1);
    drain();
    brout_in = 1'b1;
    step(5);
    push("state", 3); push("bo_rst", 1); push("vflag", 1);
    drain();
    step(1);
    push("irq_cnt", 3);
    drain();
    en = 1'b0;
    step(1);
    push("state", 0); push("ena", 0); push("bo_rst", 0); push("vflag", 0); push("irq", 0);
    drain();
    step(1);
    push("state", 0); push("vflag", 0);
    drain();
    vunder_in = 1'b0;
    brout_in  = 1'b0;
    step(3);

    // 6: re-enable latches new config; vunder flag set/clear priority
    en = 1'b1;
    step(1);
    push("otrip", 2); push("state", 1);
    drain();
    step(SETTLE);
    push("state", 2);
    drain();
    vunder_in = 1'b1;
    step(2);
    push("vflag", 0);
    drain();
    step(1);
    push("vflag", 1);
    drain();
    clr_vunder = 1'b1;
    step(1);
    clr_vunder = 1'b0;
    push("vflag", 1);
    drain();
    vunder_in = 1'b0;
    step(2);
    push("vflag", 1);
    drain();
    clr_vunder = 1'b1;
    step(1);
    clr_vunder = 1'b0;
    push("vflag", 0);
    drain();
    step(2);
    push("vflag", 0);
    drain();

    // reset mid-fault drops bo_rst on the next edge
    brout_in = 1'b1;
    step(5);
    push("state", 3); push("bo_rst", 1);
    drain();
    step(1);
`ifdef BROWNOUT_EVT_CNT_EN
    push("evt_cnt", 4);
    drain();
`endif
    rst = 1'b1;
    step(1);
    push("state", 0); push("bo_rst", 0); push("ena", 0); push("otrip", 0); push("vflag", 0);
`ifdef BROWNOUT_EVT_CNT_EN
    push("evt_cnt", 0);
`endif
    drain();
    rst = 1'b0;
    brout_in = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
